// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first.
// rxd is oversampled 16x and passes through a two-flop synchroniser.
// Each bit is decided by a majority vote of samples 7, 8 and 9.
// The stop bit is checked, and one received byte is held for the bus side
// behind a ready/ack handshake.
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int TICK_DIV = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk_bus,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [1:0]  sync_ff;
  logic        rx_s;
  state_t      state;
  logic [15:0] div_cnt;
  logic [3:0]  samp_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        s7;
  logic        s8;
  logic        high_run;
  logic        tick;
  logic        decide;
  logic        bit_val;
  logic        deliver;
  logic        frame_bad;

  assign rx_s      = sync_ff[1];
  assign busy      = (state != IDLE);
  assign tick      = (state != IDLE) && (div_cnt == TICK_LAST);
  assign decide    = tick && (samp_cnt == 4'd9);
  assign bit_val   = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign deliver   = decide && (state == STOP) && bit_val;
  assign frame_bad = decide && (state == STOP) && !bit_val;

  // Two-flop synchroniser for the asynchronous line; it resets to the idle level.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], rxd};
    end
  end

  // Tick divider and per-bit sample counter.
  // Both run only while a frame is active, so they restart from zero on entry to START.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (state == IDLE) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= samp_cnt + 4'd1;
    end else begin
      div_cnt  <= div_cnt + 16'd1;
    end
  end

  // Capture the first two of the three vote samples; the third is rx_s at decision time.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick) begin
      if (samp_cnt == 4'd7) s7 <= rx_s;
      if (samp_cnt == 4'd8) s8 <= rx_s;
    end
  end

  // Frame FSM together with the registered bus-side outputs and the sticky flags.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      high_run   <= 1'b0;
      data       <= 8'h00;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) state <= START;
        end
        START: begin
          if (decide) begin
            if (bit_val) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (bit_val) begin
              state <= IDLE;
            end else begin
              state    <= BREAK;
              high_run <= 1'b0;
            end
          end
        end
        BREAK: begin
          if (!rx_s) begin
            high_run <= 1'b0;
          end else if (tick) begin
            if (high_run) state <= IDLE;
            else          high_run <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (deliver && (!data_ready || rx_ack)) begin
        data       <= shreg;
        data_ready <= 1'b1;
      end else if (rx_ack) begin
        data_ready <= 1'b0;
      end

      if (frame_bad) begin
        frame_err <= 1'b1;
      end else if (rx_ack) begin
        frame_err <= 1'b0;
      end

      if (deliver && data_ready && !rx_ack) begin
        overrun <= 1'b1;
      end else if (rx_ack) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx at TICK_DIV=4, which gives 64 clk_bus cycles per bit.
module tb_uart_rx;

  logic       clk_bus;
  logic       rst_n;
  logic       rxd;
  logic       rx_ack;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks;
  int failures;
  int lat;

  uart_rx #(
    .CLK_FREQ(7372800),
    .BAUD    (115200)
  ) dut (
    .clk_bus   (clk_bus),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .data      (data),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one frame starting at the current negedge and ends on a negedge.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, value, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (64) @(negedge clk_bus);
    end
  endtask

  task automatic ackPulse();
    rx_ack = 1'b1;
    @(negedge clk_bus);
    rx_ack = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lat      = 0;
    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ack   = 1'b0;
    repeat (5) @(negedge clk_bus);
    checkOutput("rst_data", data, 8'h00);
    checkOutput("rst_ready", data_ready, 0);
    checkOutput("rst_ferr", frame_err, 0);
    checkOutput("rst_ovr", overrun, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_bus);

    $display("[TB] test 1: frame 0x55");
    fork
      applyStimulus(8'h55, 1'b1);
      begin
        for (int i = 1; i <= 700; i++) begin
          @(negedge clk_bus);
          if (data_ready && lat == 0) lat = i;
        end
      end
    join
    checkOutput("t1_latency", lat, 619);
    checkOutput("t1_data", data, 8'h55);
    checkOutput("t1_ready", data_ready, 1);
    ackPulse();
    checkOutput("t1_ack_ready", data_ready, 0);

    $display("[TB] test 2: short low glitch");
    repeat (64) @(negedge clk_bus);
    rxd = 1'b0;
    repeat (5) @(negedge clk_bus);
    checkOutput("t2_busy_mid", busy, 1);
    repeat (15) @(negedge clk_bus);
    rxd = 1'b1;
    repeat (128) @(negedge clk_bus);
    checkOutput("t2_busy", busy, 0);
    checkOutput("t2_ready", data_ready, 0);
    checkOutput("t2_ferr", frame_err, 0);
    checkOutput("t2_ovr", overrun, 0);

    $display("[TB] test 3: framing error then 0x3C");
    applyStimulus(8'hA5, 1'b0);
    repeat (640) @(negedge clk_bus);
    checkOutput("t3_ferr", frame_err, 1);
    checkOutput("t3_ready", data_ready, 0);
    checkOutput("t3_busy_break", busy, 1);
    rxd = 1'b1;
    repeat (128) @(negedge clk_bus);
    checkOutput("t3_busy_idle", busy, 0);
    applyStimulus(8'h3C, 1'b1);
    checkOutput("t3_data", data, 8'h3C);
    checkOutput("t3_ready2", data_ready, 1);
    checkOutput("t3_ferr_sticky", frame_err, 1);
    ackPulse();
    checkOutput("t3_ack_ferr", frame_err, 0);
    checkOutput("t3_ack_ready", data_ready, 0);

    $display("[TB] test 4: back-to-back overrun");
    repeat (64) @(negedge clk_bus);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    checkOutput("t4_data", data, 8'h11);
    checkOutput("t4_ovr", overrun, 1);
    checkOutput("t4_ready", data_ready, 1);
    ackPulse();
    checkOutput("t4_ack_ready", data_ready, 0);
    checkOutput("t4_ack_ovr", overrun, 0);
    checkOutput("t4_ack_ferr", frame_err, 0);

    $display("[TB] test 5: ack on deliver cycle");
    repeat (64) @(negedge clk_bus);
    applyStimulus(8'h42, 1'b1);
    checkOutput("t5_prior", data, 8'h42);
    fork
      applyStimulus(8'h7E, 1'b1);
      begin
        repeat (618) @(posedge clk_bus);
        @(negedge clk_bus);
        rx_ack = 1'b1;
        @(negedge clk_bus);
        rx_ack = 1'b0;
      end
    join
    checkOutput("t5_data", data, 8'h7E);
    checkOutput("t5_ready", data_ready, 1);
    checkOutput("t5_ovr", overrun, 0);

    $display("[TB] test 6: reset mid-frame");
    rxd = 1'b0;
    repeat (192) @(negedge clk_bus);
    checkOutput("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_data", data, 8'h00);
    checkOutput("t6_rst_ready", data_ready, 0);
    checkOutput("t6_rst_busy", busy, 0);
    rxd = 1'b1;
    repeat (10) @(negedge clk_bus);
    rst_n = 1'b1;
    repeat (64) @(negedge clk_bus);
    applyStimulus(8'h0F, 1'b1);
    checkOutput("t6_data", data, 8'h0F);
    checkOutput("t6_ready", data_ready, 1);
    checkOutput("t6_ovr", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
